sync_count_checker: RTL and testbench

SYNC_COUNT_CHECKER -- requirements
Module: sync_count_checker

---
 rtl/sync_count_checker.sv | 136 +++++++++++++
 tb/tb_sync_count_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_count_checker.sv
// sync_count_checker: watches a free-running 4-bit up counter, locks onto a
// clean increment sequence, counts 15->0 wraps and flags sequence errors.
module sync_count_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        count_in,
    input  logic              clear_err,
    output logic [1:0]        state,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_pulse,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 8;
    localparam logic [CNT_W-1:0] LOCK_V  = CNT_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        UNUSED  = 2'd3
    } state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    prev_q, prev_n;
    logic [CNT_W-1:0]    run_q, run_n;
    logic [CNT_W-1:0]    expected;
    logic                match;
    logic                locked_n;
    logic                wrap_pulse_n;
    logic [WRAP_W-1:0]   wrap_cnt_n;
    logic                err_pulse_n;
    logic                err_n;
    logic [ERR_W-1:0]    err_cnt_n;

    assign state = state_q;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            run_q      <= '0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            err_pulse  <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state_q    <= state_n;
            prev_q     <= prev_n;
            run_q      <= run_n;
            locked     <= locked_n;
            wrap_pulse <= wrap_pulse_n;
            wrap_cnt   <= wrap_cnt_n;
            err_pulse  <= err_pulse_n;
            err        <= err_n;
            err_cnt    <= err_cnt_n;
        end
    end

    // Next-state and next-output decode; an error on a clear edge counts from zero.
    always_comb begin
        state_n      = state_q;
        prev_n       = prev_q;
        run_n        = run_q;
        wrap_pulse_n = 1'b0;
        wrap_cnt_n   = wrap_cnt;
        err_pulse_n  = 1'b0;
        err_n        = err;
        err_cnt_n    = err_cnt;
        expected     = prev_q + CNT_W'(1);
        match        = (count_in == expected);

        if (clear_err) begin
            err_n     = 1'b0;
            err_cnt_n = '0;
        end

        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                ACQUIRE: begin
                    prev_n = count_in;
                    if (match) begin
                        run_n = run_q + CNT_W'(1);
                        if (run_n == LOCK_V) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        run_n = '0;
                    end
                end
                LOCKED: begin
                    prev_n = count_in;
                    if (match) begin
                        if (prev_q == {CNT_W{1'b1}}) begin
                            wrap_pulse_n = 1'b1;
                            wrap_cnt_n   = wrap_cnt + WRAP_W'(1);
                        end
                    end else begin
                        err_pulse_n = 1'b1;
                        err_n       = 1'b1;
                        if (clear_err) begin
                            err_cnt_n = ERR_W'(1);
                        end else if (err_cnt != ERR_MAX) begin
                            err_cnt_n = err_cnt + ERR_W'(1);
                        end
                        run_n   = '0;
                        state_n = ACQUIRE;
                    end
                end
                default: begin
                    // IDLE and the unused encoding both start a fresh acquisition.
                    prev_n  = count_in;
                    run_n   = '0;
                    state_n = ACQUIRE;
                end
            endcase
        end

        locked_n = (state_n == LOCKED);
    end

endmodule

// File: tb/tb_sync_count_checker.sv
// Directed bench for sync_count_checker with a sequence-level reference model.
module tb_sync_count_checker;

    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned WRAP_W   = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic [3:0]        count_in = 4'd0;
    logic              clear_err = 1'b0;
    logic [1:0]        d_state;
    logic              d_locked;
    logic              d_wrap_pulse;
    logic [WRAP_W-1:0] d_wrap_cnt;
    logic              d_err_pulse;
    logic              d_err;
    logic [7:0]        d_err_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;
    logic [3:0] cur = 4'd0;

    // Reference model: phase 0=idle,1=acquire,2=locked; streak of good increments.
    int phase = 0, m_prev = 0, streak = 0;
    int e_wp = 0, e_ep = 0, e_wc = 0, e_err = 0, e_ec = 0;

    sync_count_checker #(.LOCK_CNT(LOCK_CNT), .WRAP_W(WRAP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .count_in   (count_in),
        .clear_err  (clear_err),
        .state      (d_state),
        .locked     (d_locked),
        .wrap_pulse (d_wrap_pulse),
        .wrap_cnt   (d_wrap_cnt),
        .err_pulse  (d_err_pulse),
        .err        (d_err),
        .err_cnt    (d_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update on every edge, using the inputs the DUT sampled.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase = 0; m_prev = 0; streak = 0;
            e_wp = 0; e_ep = 0; e_wc = 0; e_err = 0; e_ec = 0;
        end else begin
            e_wp = 0;
            e_ep = 0;
            if (clear_err) begin
                e_err = 0;
                e_ec  = 0;
            end
            if (!en) begin
                phase = 0;
            end else if (phase == 0) begin
                m_prev = int'(count_in);
                streak = 0;
                phase  = 1;
            end else begin
                if (int'(count_in) == (m_prev + 1) % 16) begin
                    if (phase == 1) begin
                        streak = streak + 1;
                        if (streak == LOCK_CNT) phase = 2;
                    end else if (m_prev == 15) begin
                        e_wp = 1;
                        e_wc = (e_wc + 1) % (1 << WRAP_W);
                    end
                end else if (phase == 1) begin
                    streak = 0;
                end else begin
                    e_ep  = 1;
                    e_err = 1;
                    e_ec  = (e_ec < 255) ? e_ec + 1 : 255;
                    streak = 0;
                    phase  = 1;
                end
                m_prev = int'(count_in);
            end
        end
    end

    // Compare every output against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("state",      int'(d_state),      phase);
            chk("locked",     int'(d_locked),     (phase == 2) ? 1 : 0);
            chk("wrap_pulse", int'(d_wrap_pulse), e_wp);
            chk("wrap_cnt",   int'(d_wrap_cnt),   e_wc);
            chk("err_pulse",  int'(d_err_pulse),  e_ep);
            chk("err",        int'(d_err),        e_err);
            chk("err_cnt",    int'(d_err_cnt),    e_ec);
        end
    end

    task automatic step(input logic e, input logic [3:0] c, input logic clr);
        @(negedge clk);
        en        = e;
        count_in  = c;
        clear_err = clr;
        @(posedge clk);
        #2;
    endtask

    // Feed n correct consecutive counter values starting at cur.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, cur, 1'b0);
            cur = cur + 4'd1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        chk_on = 1;
        @(negedge clk);
        chk("rst_state", int'(d_state), 0);
        chk("rst_wrap_cnt", int'(d_wrap_cnt), 0);
        reset = 1'b0;

        // Lock on 0..4
        cur = 4'd0;
        run(4);
        chk("pre_lock_locked", int'(d_locked), 0);
        chk("pre_lock_state", int'(d_state), 1);
        run(1);
        chk("lock_state", int'(d_state), 2);
        chk("lock_locked", int'(d_locked), 1);
        chk("lock_err", int'(d_err), 0);

        // First wrap
        run(9);
        run(2);
        run(1);
        chk("wrap1_pulse", int'(d_wrap_pulse), 1);
        chk("wrap1_cnt", int'(d_wrap_cnt), 1);
        run(1);
        chk("wrap1_pulse_end", int'(d_wrap_pulse), 0);

        // 256 more wraps bring the counter back to 1
        run(256 * 16);
        chk("wrap256_cnt", int'(d_wrap_cnt), 1);
        run(4);
        chk("at5_state", int'(d_state), 2);

        // Error injection at 5 -> 7, then relock on 8..11
        step(1'b1, 4'd7, 1'b0);
        chk("err_pulse", int'(d_err_pulse), 1);
        chk("err_flag", int'(d_err), 1);
        chk("err_cnt1", int'(d_err_cnt), 1);
        chk("err_locked", int'(d_locked), 0);
        chk("err_state", int'(d_state), 1);
        cur = 4'd8;
        run(3);
        chk("relock_pending", int'(d_locked), 0);
        run(1);
        chk("relock_locked", int'(d_locked), 1);
        chk("relock_err_pulse", int'(d_err_pulse), 0);

        // Second wrap, then enable drop
        run(5);
        chk("wrap2_cnt", int'(d_wrap_cnt), 2);
        for (int i = 0; i < 3; i++) step(1'b0, cur, 1'b0);
        chk("endrop_state", int'(d_state), 0);
        chk("endrop_locked", int'(d_locked), 0);
        chk("endrop_wp", int'(d_wrap_pulse), 0);
        chk("endrop_ep", int'(d_err_pulse), 0);
        chk("endrop_wc", int'(d_wrap_cnt), 2);
        chk("endrop_ec", int'(d_err_cnt), 1);
        chk("endrop_err", int'(d_err), 1);
        run(5);
        chk("reen_locked", int'(d_locked), 1);

        // Clear colliding with a locked mismatch: error counts from zero
        step(1'b1, cur + 4'd3, 1'b1);
        chk("coll_err_cnt", int'(d_err_cnt), 1);
        chk("coll_err", int'(d_err), 1);
        chk("coll_pulse", int'(d_err_pulse), 1);
        cur = cur + 4'd4;
        run(4);
        // Plain clear while locked leaves the FSM alone
        step(1'b1, cur, 1'b1);
        cur = cur + 4'd1;
        chk("clr_err_cnt", int'(d_err_cnt), 0);
        chk("clr_err", int'(d_err), 0);
        chk("clr_state", int'(d_state), 2);

        // 300 errors with relock in between saturate the error count
        for (int i = 0; i < 300; i++) begin
            step(1'b1, cur + 4'd1, 1'b0);
            cur = cur + 4'd2;
            run(4);
        end
        chk("sat_err_cnt", int'(d_err_cnt), 255);
        chk("sat_locked", int'(d_locked), 1);

        // Asynchronous reset between edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_state", int'(d_state), 0);
        chk("areset_locked", int'(d_locked), 0);
        chk("areset_wc", int'(d_wrap_cnt), 0);
        chk("areset_ec", int'(d_err_cnt), 0);
        chk("areset_err", int'(d_err), 0);
        chk("areset_pulses", int'(d_wrap_pulse) + int'(d_err_pulse), 0);
        @(negedge clk);
        reset = 1'b0;
        cur = 4'd9;
        run(1);
        chk("post_rst_state", int'(d_state), 1);
        run(4);
        chk("post_rst_locked", int'(d_locked), 1);

        // A disabled edge followed by an enabled one
        step(1'b0, cur, 1'b0);
        run(1);
        chk("reacq_state", int'(d_state), 1);

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
